// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution front-end: window state encoding and
// the flat window-word index helper.
package cnn_pkg;

    // Window generator phase: FILL while the first K-1 rows are buffered.
    typedef enum logic [0:0] {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } win_state_e;

    // Bit offset of window element (r,c) inside the flat window word.
    function automatic int unsigned win_offset(
        input int unsigned r,
        input int unsigned c,
        input int unsigned k,
        input int unsigned data_w
    );
        return (r * k + c) * data_w;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle of the sliding-window generator.
interface conv_window_gen_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned K      = 3
);
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    win_valid;
    logic [K*K*DATA_W-1:0]   win_data;
    logic                    frame_done;

    // Pixel source side.
    modport master (
        output in_valid,
        output in_data,
        input  win_valid,
        input  win_data,
        input  frame_done
    );

    // Window generator side.
    modport slave (
        input  in_valid,
        input  in_data,
        output win_valid,
        output win_data,
        output frame_done
    );
endinterface

// File: rtl/line_delay.sv
// Fixed-depth shift delay: dout is the sample accepted DEPTH enables ago.
module line_delay #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Shift one position per enabled cycle; hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en) begin
            mem_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator: buffers K-1 image rows and emits one flat
// window word per pixel that completes a fully in-image neighbourhood.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned K      = 3
) (
    input  logic              clk,
    input  logic              reset,
    conv_window_gen_if.slave  io
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    win_state_e       state_q, state_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             last_col_c, last_row_c;

    // tap[i] is the input stream delayed by i image rows.
    logic [DATA_W-1:0] tap [K];

    // Window element (r,c) sits at bits (r*K+c)*DATA_W of the packed word.
    logic [K-1:0][K-1:0][DATA_W-1:0] win_q;

    assign tap[0] = io.in_data;

    // Cascaded row delays feeding the upper window rows.
    for (genvar g = 1; g < K; g++) begin : g_row_dly
        line_delay #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_line_delay (
            .clk    (clk),
            .reset  (reset),
            .en     (io.in_valid),
            .din    (tap[g-1]),
            .dout   (tap[g])
        );
    end

    assign last_col_c = (col_q == COL_W'(IMG_W - 1));
    assign last_row_c = (row_q == ROW_W'(IMG_H - 1));

    // Next-state, position counters and window strobes; all advance on accept only.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (io.in_valid) begin
            if (last_col_c) begin
                col_d = '0;
                row_d = last_row_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            case (state_q)
                FILL: begin
                    // Last pixel of row K-2: the next row completes full windows.
                    if (last_col_c && (row_q == ROW_W'(K - 2))) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    win_valid_d = (col_q >= COL_W'(K - 1));
                    if (last_col_c && last_row_c) begin
                        state_d      = FILL;
                        frame_done_d = 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State, counters and output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Window registers: each row shifts left and takes its row tap on the right.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
        end else if (io.in_valid) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c + 1 < K; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= tap[K-1-r];
            end
        end
    end

    assign io.win_valid  = win_valid_q;
    assign io.frame_done = frame_done_q;
    assign io.win_data   = win_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 4x4 and 5x3 images, K=3, 16-bit pixels.
module tb_conv_window_gen;
    import cnn_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    conv_window_gen_if #(.DATA_W(16), .K(3)) a_if ();
    conv_window_gen_if #(.DATA_W(16), .K(3)) b_if ();

    conv_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .K(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .io    (a_if)
    );

    conv_window_gen #(.DATA_W(16), .IMG_W(5), .IMG_H(3), .K(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .io    (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected window for the pixel at (row,col) of a frame whose pixel (0,0) is base.
    function automatic logic [255:0] win_model(input int base, input int w, input int row, input int col);
        logic [255:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v[win_offset(r, c, 3, 16) +: 16] = 16'(base + (row - 2 + r) * w + (col - 2 + c));
            end
        end
        return v;
    endfunction

    function automatic logic [255:0] pack9(input int e [9]);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) begin
            v[i*16 +: 16] = 16'(e[i]);
        end
        return v;
    endfunction

    task automatic drive(input bit use_b, input logic v, input logic [15:0] d);
        if (use_b) begin
            b_if.in_valid = v;
            b_if.in_data  = d;
        end else begin
            a_if.in_valid = v;
            a_if.in_data  = d;
        end
    endtask

    task automatic sample(input bit use_b, output logic v, output logic fd, output logic [143:0] wd);
        if (use_b) begin
            v  = b_if.win_valid;
            fd = b_if.frame_done;
            wd = b_if.win_data;
        end else begin
            v  = a_if.win_valid;
            fd = a_if.frame_done;
            wd = a_if.win_data;
        end
    endtask

    // One full frame of pixels base..base+w*h-1 with 'gap' idle cycles after each accept.
    task automatic run_frame(input bit use_b, input int w, input int h, input int base, input int gap,
                             input string tag, output logic [255:0] first_w, output logic [255:0] last_w);
        int           pulses;
        bit           exp_v;
        logic         v;
        logic         fd;
        logic [143:0] wd;
        pulses  = 0;
        first_w = '0;
        last_w  = '0;
        for (int i = 0; i < w * h; i++) begin
            drive(use_b, 1'b1, 16'(base + i));
            @(posedge clk);
            @(negedge clk);
            drive(use_b, 1'b0, 16'(0));
            sample(use_b, v, fd, wd);
            exp_v = ((i / w) >= 2) && ((i % w) >= 2);
            check_eq($sformatf("%s px%0d win_valid", tag, i + 1), 256'(v), 256'(exp_v));
            check_eq($sformatf("%s px%0d frame_done", tag, i + 1), 256'(fd), 256'(i == w * h - 1));
            if (exp_v) begin
                check_eq($sformatf("%s px%0d win_data", tag, i + 1), 256'(wd), win_model(base, w, i / w, i % w));
            end
            if (v) begin
                pulses++;
                if (pulses == 1) first_w = 256'(wd);
                last_w = 256'(wd);
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                @(negedge clk);
                sample(use_b, v, fd, wd);
                check_eq($sformatf("%s px%0d idle%0d win_valid", tag, i + 1, g), 256'(v), 256'(0));
                check_eq($sformatf("%s px%0d idle%0d frame_done", tag, i + 1, g), 256'(fd), 256'(0));
            end
        end
        check_eq($sformatf("%s pulse count", tag), 256'(pulses), 256'((w - 2) * (h - 2)));
    endtask

    initial begin
        logic [255:0] fw;
        logic [255:0] lw;
        int           hand [9];

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 16'(0));
        drive(1'b1, 1'b0, 16'(0));
        repeat (2) @(negedge clk);

        check_eq("reset win_valid", 256'(a_if.win_valid), 256'(0));
        check_eq("reset frame_done", 256'(a_if.frame_done), 256'(0));
        check_eq("reset win_data", 256'(a_if.win_data), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        // Continuous stream.
        run_frame(1'b0, 4, 4, 1, 0, "cont", fw, lw);
        hand = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        check_eq("cont first window", fw, pack9(hand));
        hand = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        check_eq("cont last window", lw, pack9(hand));

        // Three idle cycles after every accept.
        run_frame(1'b0, 4, 4, 1, 3, "gap", fw, lw);
        hand = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        check_eq("gap first window", fw, pack9(hand));
        hand = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        check_eq("gap last window", lw, pack9(hand));

        // Back-to-back frames.
        run_frame(1'b0, 4, 4, 1, 0, "b2b f1", fw, lw);
        run_frame(1'b0, 4, 4, 101, 0, "b2b f2", fw, lw);
        hand = '{101, 102, 103, 105, 106, 107, 109, 110, 111};
        check_eq("b2b f2 first window", fw, pack9(hand));

        // Partial frame, then asynchronous reset away from any clock edge.
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 16'(1 + i));
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 16'(0));
        check_eq("pre-reset win_data nonzero", 256'(a_if.win_data != '0), 256'(1));
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid reset win_valid", 256'(a_if.win_valid), 256'(0));
        check_eq("mid reset frame_done", 256'(a_if.frame_done), 256'(0));
        check_eq("mid reset win_data", 256'(a_if.win_data), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame(1'b0, 4, 4, 1, 0, "post-reset", fw, lw);
        hand = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        check_eq("post-reset first window", fw, pack9(hand));
        hand = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        check_eq("post-reset last window", lw, pack9(hand));

        // 5x3 image: windows only in row 2, two frames to cover the wrap.
        run_frame(1'b1, 5, 3, 1, 0, "w5h3 f1", fw, lw);
        hand = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        check_eq("w5h3 f1 first window", fw, pack9(hand));
        hand = '{3, 4, 5, 8, 9, 10, 13, 14, 15};
        check_eq("w5h3 f1 last window", lw, pack9(hand));
        run_frame(1'b1, 5, 3, 1, 0, "w5h3 f2", fw, lw);
        hand = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        check_eq("w5h3 f2 first window", fw, pack9(hand));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator sitting directly downstream of the pixel input stream and upstream of the convolution MAC array. It accepts a raster-order pixel stream one pixel per accepted cycle and buffers K-1 image rows internally. For every pixel that completes a fully in-image K×K neighbourhood, it presents that neighbourhood as one flat window word with a one-cycle valid strobe. It is the reading end of the line-delay chain: it consumes the delayed taps, gates them by image position, and decides when a window is real.

## Interface
- DATA_W, 16, pixel width in bits
- IMG_W, 8, image width in pixels; must satisfy IMG_W >= K
- IMG_H, 8, image height in pixels; must satisfy IMG_H >= K
- K, 3, window edge length; must be >= 2

- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  in_data is a pixel to accept this cycle; no backpressure
- in_data  input  DATA_W  pixel value, raster order, unsigned
- win_valid  output  1  win_data holds a complete window; one-cycle pulse per window
- win_data  output  K*K*DATA_W  window; element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept a pixel on every rising edge with in_valid=1. With in_valid=0, hold all state unchanged, including line buffers, window registers and counters.
- Position counters:
  - col counts 0..IMG_W-1.
  - row counts 0..IMG_H-1.
  - col advances per accepted pixel. At IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts with no idle cycle.
- Line buffers: K-1 cascaded delays of exactly IMG_W accepted pixels each. Each shifts only on accept. Row r of the window is fed from delay tap (K-1-r).
- Window registers: K rows × K columns. On accept, each row shifts left by one and its new rightmost element takes that row's tap.
- Window element mapping:
  - (0,0) is the oldest pixel (top-left).
  - (K-1,K-1) is the pixel just accepted (bottom-right).
- State machine, state advances on accept only:
  - FILL: row < K-1. No windows produced. Move to ACTIVE when row reaches K-1.
  - ACTIVE: a window is valid for an accepted pixel when col >= K-1. Return to FILL on frame wrap.
- No padding; edge-straddling windows are never flagged. Windows per frame = (IMG_W-K+1)*(IMG_H-K+1).
- Stale data from the previous frame stays in the buffers but is masked by the FILL state and the col gating.
- Reset, including mid-frame: counters 0, state FILL, line buffers and window registers 0, win_valid=0, frame_done=0. A partial frame is discarded and the next accepted pixel is (0,0).

## Timing
- Latency: window for the pixel accepted at edge n is visible after edge n, i.e. win_valid is high during cycle n+1.
- win_valid and frame_done are registered and are never high on consecutive cycles without a corresponding accept.
- win_data holds its value between windows. It changes only on accept and is don't-care while win_valid=0.
- frame_done is coincident with the final window's win_valid.
- Reset values: win_valid=0, frame_done=0, win_data=0.
- Throughput: one pixel per cycle sustained.

## Structure
- Shared package `cnn_pkg` holds:
  - window index helper: offset = (r*K+c)*DATA_W
  - state encoding: FILL, ACTIVE
- Sub-module `line_delay`: depth-IMG_W, width-DATA_W shift delay with an enable input and async active-high reset, instantiated K-1 times in a chain.
- Counters, FSM, window registers and output registers live in the top module.

## Test plan
Default bench configuration: IMG_W=4, IMG_H=4, K=3, DATA_W=16, pixels 1..16 in raster order.
- Continuous stream:
  - Exactly 4 win_valid pulses, one cycle after pixels 11, 12, 15 and 16.
  - First window = 1,2,3,5,6,7,9,10,11.
  - Last window = 6,7,8,10,11,12,14,15,16.
  - frame_done high only with the fourth pulse.
- Same frame with in_valid=0 for 3 cycles after every accepted pixel: identical window contents and count, with each pulse one cycle after its accept.
- Two frames back-to-back (1..16, then 101..116): no window before the second frame's pixel 11. Its first window = 101,102,103,105,106,107,109,110,111.
- Assert reset asynchronously mid-cycle after pixel 9, then restart with 1..16:
  - outputs drop to 0 immediately
  - afterwards, results match the continuous-stream case exactly
- Parameter sweep IMG_W=5, IMG_H=3, K=3: windows appear only in row 2, 3 per frame. Row 2's first window = 1,2,3,6,7,8,11,12,13.
